// File: rtl/uart_tx_dev.sv
// Bus-attached UART transmitter: byte FIFO drained as 8N1 frames on tx_o,
// with a programmable bit period and a level interrupt on idle/empty.
module uart_tx_dev #(
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned AddressWidth = 32,
  parameter int unsigned FifoDepth    = 8,
  parameter logic [15:0] ClkDivReset  = 16'd867
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    uart_req_i,
  input  logic                    uart_we_i,
  input  logic [3:0]              uart_be_i,
  input  logic [AddressWidth-1:0] uart_addr_i,
  input  logic [DataWidth-1:0]    uart_wdata_i,
  output logic                    uart_rvalid_o,
  output logic [DataWidth-1:0]    uart_rdata_o,
  output logic                    uart_err_o,
  output logic                    tx_o,
  output logic                    uart_irq_o
);
  localparam int unsigned PtrW = $clog2(FifoDepth);
  localparam int unsigned LvlW = PtrW + 1;
  localparam logic [LvlW-1:0] LvlFull = LvlW'(FifoDepth);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e          state_q, state_d;
  logic            tx_q, tx_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [15:0]     div_q, div_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0] level_q, level_d;
  logic [7:0]      fifo_mem_q [FifoDepth];
  logic            ovf_q, ovf_d;
  logic [15:0]     clkdiv_q, clkdiv_d;
  logic            en_q, en_d, irq_en_q, irq_en_d;
  logic            rvalid_q, rvalid_d, err_q, err_d;
  logic [DataWidth-1:0] rdata_q, rdata_d;

  logic       addr_err, wr_en, rd_en;
  logic [1:0] reg_sel;
  logic       fifo_empty, fifo_full, busy, fifo_pop, push_req, push_ok;
  logic       bit_end, can_start;
  logic [7:0] fifo_head;

  logic unused_bits;
  assign unused_bits = ^{uart_addr_i[AddressWidth-1:10], uart_wdata_i[DataWidth-1:16],
                         uart_be_i[3:2]};

  always_comb begin
    addr_err = (uart_addr_i[1:0] != 2'b00) || (uart_addr_i[9:4] != 6'd0);
    reg_sel  = uart_addr_i[3:2];
    wr_en    = uart_req_i & uart_we_i & ~addr_err;
    rd_en    = uart_req_i & ~uart_we_i & ~addr_err;
  end

  always_comb begin
    fifo_empty = (level_q == '0);
    fifo_full  = (level_q == LvlFull);
    busy       = (state_q != StIdle);
    fifo_head  = fifo_mem_q[rd_ptr_q];
  end

  // A full FIFO still accepts a byte when the transmitter pops in the same cycle.
  always_comb begin
    push_req = wr_en && (reg_sel == 2'd0) && uart_be_i[0];
    push_ok  = push_req && (!fifo_full || fifo_pop);
    wr_ptr_d = wr_ptr_q + PtrW'(push_ok);
    rd_ptr_d = rd_ptr_q + PtrW'(fifo_pop);
    level_d  = level_q;
    if (push_ok && !fifo_pop)      level_d = level_q + 1'b1;
    else if (!push_ok && fifo_pop) level_d = level_q - 1'b1;
  end

  always_comb begin
    clkdiv_d = clkdiv_q;
    en_d     = en_q;
    irq_en_d = irq_en_q;
    ovf_d    = ovf_q;
    if (wr_en && (reg_sel == 2'd2)) begin
      if (uart_be_i[0]) clkdiv_d[7:0]  = uart_wdata_i[7:0];
      if (uart_be_i[1]) clkdiv_d[15:8] = uart_wdata_i[15:8];
    end
    if (wr_en && (reg_sel == 2'd3) && uart_be_i[0]) begin
      en_d     = uart_wdata_i[0];
      irq_en_d = uart_wdata_i[1];
    end
    if (wr_en && (reg_sel == 2'd1) && uart_be_i[0] && uart_wdata_i[3]) ovf_d = 1'b0;
    if (push_req && !push_ok) ovf_d = 1'b1;
  end

  always_comb begin
    rvalid_d = uart_req_i;
    err_d    = uart_req_i & addr_err;
    rdata_d  = '0;
    if (rd_en) begin
      case (reg_sel)
        2'd1:    rdata_d = DataWidth'({16'd0, 8'(level_q), 4'd0, ovf_q, busy, fifo_empty, fifo_full});
        2'd2:    rdata_d = DataWidth'({16'd0, clkdiv_q});
        2'd3:    rdata_d = DataWidth'({30'd0, irq_en_q, en_q});
        default: rdata_d = '0;
      endcase
    end
  end

  // The divider shadow div_q is loaded only at frame start, so CLKDIV writes
  // during a frame take effect on the next one.
  always_comb begin
    state_d   = state_q;
    tx_d      = tx_q;
    cnt_d     = cnt_q;
    div_d     = div_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    fifo_pop  = 1'b0;
    bit_end   = (cnt_q == div_q);
    can_start = en_q && !fifo_empty;
    case (state_q)
      StIdle: begin
        tx_d = 1'b1;
        if (can_start) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_head;
          div_d    = clkdiv_q;
          cnt_d    = '0;
          tx_d     = 1'b0;
          state_d  = StStart;
        end
      end
      StStart: begin
        if (bit_end) begin
          cnt_d   = '0;
          bit_d   = '0;
          tx_d    = shift_q[0];
          shift_d = {1'b0, shift_q[7:1]};
          state_d = StData;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StData: begin
        if (bit_end) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = StStop;
          end else begin
            tx_d    = shift_q[0];
            shift_d = {1'b0, shift_q[7:1]};
            bit_d   = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StStop: begin
        if (bit_end) begin
          cnt_d = '0;
          if (can_start) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_head;
            div_d    = clkdiv_q;
            tx_d     = 1'b0;
            state_d  = StStart;
          end else begin
            tx_d    = 1'b1;
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      tx_q     <= 1'b1;
      cnt_q    <= '0;
      div_q    <= '0;
      bit_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      clkdiv_q <= ClkDivReset;
      en_q     <= 1'b0;
      irq_en_q <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      tx_q     <= tx_d;
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
      clkdiv_q <= clkdiv_d;
      en_q     <= en_d;
      irq_en_q <= irq_en_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // Byte storage needs no reset: validity is tracked by the pointers and level.
  always_ff @(posedge clk_i) begin
    if (push_ok) fifo_mem_q[wr_ptr_q] <= uart_wdata_i[7:0];
    shift_q <= shift_d;
  end

  assign uart_rvalid_o = rvalid_q;
  assign uart_rdata_o  = rdata_q;
  assign uart_err_o    = err_q;
  assign tx_o          = tx_q;
  assign uart_irq_o    = irq_en_q & fifo_empty & ~busy;

endmodule

// File: tb/tb_uart_tx_dev.sv
// Directed bench for uart_tx_dev: bus responses and serial frames are checked
// against queues of expectations filled as stimulus is driven.
module tb_uart_tx_dev;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0, we = 1'b0;
  logic [3:0]  be = 4'h0;
  logic [31:0] addr = 32'h0, wdata = 32'h0;
  logic        rvalid, err, tx, irq;
  logic [31:0] rdata;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t;
  logic req_prev = 1'b0;

  typedef struct { logic [31:0] rdata; logic err; } rsp_t;
  typedef struct { logic [7:0] b; int p; } frm_t;
  rsp_t rsp_q[$];
  frm_t rx_q[$];
  int   starts_q[$];

  uart_tx_dev dut (
    .clk_i(clk), .rst_i(rst), .uart_req_i(req), .uart_we_i(we), .uart_be_i(be),
    .uart_addr_i(addr), .uart_wdata_i(wdata), .uart_rvalid_o(rvalid),
    .uart_rdata_o(rdata), .uart_err_o(err), .tx_o(tx), .uart_irq_o(irq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    req_prev <= rst ? 1'b0 : req;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Bus response scoreboard: one response per request, exactly one cycle later.
  always @(negedge clk) begin : rsp_mon
    rsp_t r;
    if (!rst) begin
      chk("rvalid", 32'(rvalid), 32'(req_prev));
      if (rvalid === 1'b1) begin
        if (rsp_q.size() == 0) chk("rsp_pending", 32'(rsp_q.size()), 32'd1);
        else begin
          r = rsp_q.pop_front();
          chk("rdata", rdata, r.rdata);
          chk("err", 32'(err), 32'(r.err));
        end
      end else begin
        chk("rdata_idle", rdata, 32'h0);
      end
    end
  end

  // Serial receiver: every cycle of each frame is compared against the expected level.
  initial begin : rx_mon
    frm_t f;
    logic [9:0] frame;
    forever begin
      @(negedge clk);
      if (!rst && tx === 1'b0) begin
        starts_q.push_back(cyc);
        if (rx_q.size() == 0) begin
          chk("rx_unexpected_frame", 32'(rx_q.size()), 32'd1);
          while (tx !== 1'b1) @(negedge clk);
        end else begin
          f = rx_q.pop_front();
          frame = {1'b1, f.b, 1'b0};
          for (int c = 0; c < 10 * f.p; c++) begin
            if (c > 0) @(negedge clk);
            if (rst) break;
            chk("tx_bit", 32'(tx), 32'(frame[c / f.p]));
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

  task automatic bus(input logic w, input logic [3:0] b, input logic [31:0] a,
                     input logic [31:0] d, input logic [31:0] er, input logic ee);
    rsp_t r;
    req = 1'b1; we = w; be = b; addr = a; wdata = d;
    r.rdata = er; r.err = ee;
    rsp_q.push_back(r);
    @(negedge clk);
    req = 1'b0; we = 1'b0; be = 4'h0; addr = 32'h0; wdata = 32'h0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    bus(1'b1, b, a, d, 32'h0, 1'b0);
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp);
    bus(1'b0, 4'hF, a, 32'h0, exp, 1'b0);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic chk_start(input string tag, input int exp);
    if (starts_q.size() == 0) chk(tag, 32'(starts_q.size()), 32'd1);
    else chk(tag, 32'(starts_q.pop_front()), 32'(exp));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_tx", 32'(tx), 32'd1);
    chk("reset_irq", 32'(irq), 32'd0);
    rd(32'h4, 32'h2);
    rd(32'h8, 32'd867);
    rd(32'hC, 32'h0);

    // Single frame, P=4
    wr(32'h8, 32'd3, 4'b0011);
    wr(32'hC, 32'd1, 4'b0001);
    starts_q.delete();
    rx_q.push_back('{8'hA5, 4});
    t = cyc;
    wr(32'h0, 32'hA5, 4'b0001);
    wait_until(t + 41);
    rd(32'h4, 32'h6);
    rd(32'h4, 32'h2);
    chk_start("start_single", t + 2);

    // Back-to-back frames, P=1
    wr(32'h8, 32'd0, 4'b0011);
    starts_q.delete();
    rx_q.push_back('{8'h55, 1});
    rx_q.push_back('{8'h0F, 1});
    t = cyc;
    wr(32'h0, 32'h55, 4'b0001);
    wr(32'h0, 32'h0F, 4'b0001);
    wait_until(t + 24);
    rd(32'h4, 32'h2);
    chk_start("start_b2b_1", t + 2);
    chk_start("start_b2b_2", t + 12);

    // Overflow with transmitter disabled
    wr(32'hC, 32'd0, 4'b0001);
    for (int i = 0; i < 9; i++) wr(32'h0, 32'h10 + i, 4'b0001);
    rd(32'h4, 32'h809);
    wr(32'h4, 32'h8, 4'b0001);
    rd(32'h4, 32'h801);
    for (int i = 0; i < 8; i++) rx_q.push_back('{8'(8'h10 + i), 1});
    wr(32'hC, 32'd1, 4'b0001);
    t = cyc;
    wait_until(t + 86);
    rd(32'h4, 32'h2);
    chk("ovf_rx_drained", 32'(rx_q.size()), 32'd0);

    // Reset in the middle of a frame
    wr(32'h8, 32'd3, 4'b0011);
    rx_q.push_back('{8'h3C, 4});
    t = cyc;
    wr(32'h0, 32'h3C, 4'b0001);
    wait_until(t + 10);
    #2 rst = 1'b1;
    #1 chk("tx_async_reset", 32'(tx), 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_rx_consumed", 32'(rx_q.size()), 32'd0);
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_irq", 32'(irq), 32'd0);
    rd(32'h4, 32'h2);
    rd(32'h8, 32'h363);
    rd(32'hC, 32'h0);

    // Errors and byte enables
    wr(32'h8, 32'h1234, 4'b0001);
    rd(32'h8, 32'h334);
    bus(1'b1, 4'hF, 32'h9, 32'hFFFF, 32'h0, 1'b1);
    rd(32'h8, 32'h334);
    bus(1'b0, 4'hF, 32'h10, 32'h0, 32'h0, 1'b1);
    bus(1'b1, 4'hF, 32'h10, 32'hFFFF_FFFF, 32'h0, 1'b1);
    bus(1'b1, 4'h1, 32'h40, 32'h77, 32'h0, 1'b1);
    wr(32'h0, 32'h77, 4'b0010);
    rd(32'h4, 32'h2);
    rd(32'h0, 32'h0);
    rd(32'hC, 32'h0);

    // Interrupt and mid-frame CLKDIV change
    wr(32'h8, 32'd3, 4'b0011);
    wr(32'hC, 32'd3, 4'b0001);
    chk("irq_idle_empty", 32'(irq), 32'd1);
    starts_q.delete();
    rx_q.push_back('{8'h96, 4});
    t = cyc;
    wr(32'h0, 32'h96, 4'b0001);
    chk("irq_after_push", 32'(irq), 32'd0);
    wait_until(t + 5);
    wr(32'h8, 32'd1, 4'b0011);
    rx_q.push_back('{8'h3A, 2});
    wr(32'h0, 32'h3A, 4'b0001);
    wait_until(t + 30);
    chk("irq_busy", 32'(irq), 32'd0);
    wait_until(t + 61);
    chk("irq_last_stop", 32'(irq), 32'd0);
    @(negedge clk);
    chk("irq_back_idle", 32'(irq), 32'd1);
    chk_start("start_old_p", t + 2);
    chk_start("start_new_p", t + 42);

    // Clearing enable mid-frame leaves the remainder queued
    rx_q.push_back('{8'hC3, 2});
    t = cyc;
    wr(32'h0, 32'hC3, 4'b0001);
    wr(32'h0, 32'h81, 4'b0001);
    chk("irq_queued", 32'(irq), 32'd0);
    wait_until(t + 5);
    wr(32'hC, 32'd2, 4'b0001);
    wait_until(t + 40);
    rd(32'h4, 32'h100);
    chk("irq_not_empty", 32'(irq), 32'd0);
    chk("dis_rx_done", 32'(rx_q.size()), 32'd0);
    chk_start("start_dis", t + 2);
    chk("dis_no_more_frames", 32'(starts_q.size()), 32'd0);
    rx_q.push_back('{8'h81, 2});
    t = cyc;
    wr(32'hC, 32'd3, 4'b0001);
    wait_until(t + 21);
    chk("irq_resume_busy", 32'(irq), 32'd0);
    @(negedge clk);
    chk("irq_resume_idle", 32'(irq), 32'd1);
    chk_start("start_resume", t + 2);

    repeat (3) @(negedge clk);
    chk("rsp_all_seen", 32'(rsp_q.size()), 32'd0);
    chk("rx_all_seen", 32'(rx_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
